hazard_control: RTL and testbench

Pipeline sequencing controller for the five-stage RV32 core. It decides each cycle whether each pipeline register advances, holds or is flushed. It sits between the ID/EX/MEM stage control signals (produced downstream of the main opcode decoder) and the PC / IF-ID / ID-EX / EX-MEM register enables. It handles load-use stalls, taken-branch/jump redirects and multi-cycle data-memory waits with a timeout, and keeps saturating stall/flush event counters for debug.

---
 rtl/hazard_pkg.sv | 30 +++
 rtl/sat_counter.sv | 24 ++
 rtl/hazard_control.sv | 122 ++++++++++++
 tb/tb_hazard_control.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller: FSM states,
// the enable/flush bundle layout and the preset bundles the priority mux selects.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } hz_state_t;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic idex_write;
        logic exmem_write;
        logic ifid_flush;
        logic idex_flush;
    } hz_ctrl_t;

    localparam hz_ctrl_t CTRL_NORMAL   = 6'b1111_00;
    localparam hz_ctrl_t CTRL_FREEZE   = 6'b0000_00;
    localparam hz_ctrl_t CTRL_REDIRECT = 6'b1111_11;
    localparam hz_ctrl_t CTRL_LOAD_USE = 6'b0011_01;

    // wait_cnt must be able to hold MEM_TIMEOUT itself.
    function automatic int wait_cnt_w(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + W'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/hazard_control.sv
// Pipeline sequencing controller: memory-wait FSM with timeout, and a
// freeze > redirect > load-use priority mux driving the pipeline register enables.
module hazard_control
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W  = 5,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable_hazard_control,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs2,
    input  logic                  ex_memread,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_branch_taken,
    input  logic                  ex_jump,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    output logic                  pc_write,
    output logic                  ifid_write,
    output logic                  idex_write,
    output logic                  exmem_write,
    output logic                  ifid_flush,
    output logic                  idex_flush,
    output logic                  mem_error,
    output logic [CNT_W-1:0]      stall_count,
    output logic [CNT_W-1:0]      flush_count
);

    localparam int WCW = wait_cnt_w(MEM_TIMEOUT);

    hz_state_t      r_state, w_state_nxt;
    logic [WCW-1:0] r_wait_cnt, w_wait_cnt_nxt;

    logic     w_freeze, w_redirect, w_load_use, w_take_redirect;
    hz_ctrl_t w_ctrl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
        end
    end

    // NOTE: defaults first so every path assigns every output; otherwise a latch is inferred.
    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        unique case (r_state)
            RUN: begin
                if (mem_req && !mem_ready) begin
                    w_state_nxt    = WAIT;
                    w_wait_cnt_nxt = WCW'(1);
                end
            end
            WAIT: begin
                if (mem_ready) begin
                    w_state_nxt    = RUN;
                    w_wait_cnt_nxt = '0;
                end else if (r_wait_cnt == WCW'(MEM_TIMEOUT - 1)) begin
                    w_state_nxt = ERR;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + WCW'(1);
                end
            end
            ERR:     w_state_nxt = ERR;
            default: w_state_nxt = RUN;
        endcase
    end

    assign w_freeze = ((r_state == RUN) && mem_req && !mem_ready)
                    || ((r_state == WAIT) && !mem_ready)
                    || (r_state == ERR);

    assign w_redirect = ex_branch_taken || ex_jump;

    assign w_load_use = enable_hazard_control && ex_memread && (ex_rd != '0)
                      && ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));

    // Everything is held while reset is asserted, even though the FSM reads as RUN.
    always_comb begin
        w_ctrl = CTRL_NORMAL;
        if (!rst_n || w_freeze) begin
            w_ctrl = CTRL_FREEZE;
        end else if (w_redirect) begin
            w_ctrl = CTRL_REDIRECT;
        end else if (w_load_use) begin
            w_ctrl = CTRL_LOAD_USE;
        end
    end

    assign w_take_redirect = rst_n && !w_freeze && w_redirect;

    assign pc_write    = w_ctrl.pc_write;
    assign ifid_write  = w_ctrl.ifid_write;
    assign idex_write  = w_ctrl.idex_write;
    assign exmem_write = w_ctrl.exmem_write;
    assign ifid_flush  = w_ctrl.ifid_flush;
    assign idex_flush  = w_ctrl.idex_flush;
    assign mem_error   = (r_state == ERR);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (!w_ctrl.pc_write),
        .count (stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_take_redirect),
        .count (flush_count)
    );

endmodule

// File: tb/tb_hazard_control.sv
// Self-checking bench for hazard_control: a per-cycle reference model plus
// directed scenarios with hand-computed expectations.
module tb_hazard_control;

    localparam int REG_ADDR_W  = 5;
    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_W       = 3;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n;
    logic enable_hazard_control;
    logic [REG_ADDR_W-1:0] id_rs1, id_rs2, ex_rd;
    logic id_uses_rs2, ex_memread, ex_branch_taken, ex_jump, mem_req, mem_ready;
    logic pc_write, ifid_write, idex_write, exmem_write, ifid_flush, idex_flush, mem_error;
    logic [CNT_W-1:0] stall_count, flush_count;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    hazard_control #(
        .REG_ADDR_W  (REG_ADDR_W),
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .enable_hazard_control (enable_hazard_control),
        .id_rs1                (id_rs1),
        .id_rs2                (id_rs2),
        .id_uses_rs2           (id_uses_rs2),
        .ex_memread            (ex_memread),
        .ex_rd                 (ex_rd),
        .ex_branch_taken       (ex_branch_taken),
        .ex_jump               (ex_jump),
        .mem_req               (mem_req),
        .mem_ready             (mem_ready),
        .pc_write              (pc_write),
        .ifid_write            (ifid_write),
        .idex_write            (idex_write),
        .exmem_write           (exmem_write),
        .ifid_flush            (ifid_flush),
        .idex_flush            (idex_flush),
        .mem_error             (mem_error),
        .stall_count           (stall_count),
        .flush_count           (flush_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [5:0] bundle();
        return {pc_write, ifid_write, idex_write, exmem_write, ifid_flush, idex_flush};
    endfunction

    // Reference model: a not-ready streak counter and an error flag.
    bit m_err, m_wait;
    int m_streak, m_stall, m_flush;

    always @(negedge clk) begin
        bit pending, freeze, redirect, lu;
        logic [5:0] exp_vec;
        if (!rst_n) begin
            m_err = 0; m_wait = 0; m_streak = 0; m_stall = 0; m_flush = 0;
            check("reset_bundle", 32'(bundle()), 32'h0);
            check("reset_mem_error", 32'(mem_error), 32'h0);
            check("reset_stall_count", 32'(stall_count), 32'h0);
            check("reset_flush_count", 32'(flush_count), 32'h0);
        end else begin
            pending  = m_wait || mem_req;
            freeze   = m_err || (pending && !mem_ready);
            redirect = ex_branch_taken || ex_jump;
            lu = enable_hazard_control && ex_memread && (ex_rd != 0)
                 && ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));
            if (freeze)        exp_vec = 6'b000000;
            else if (redirect) exp_vec = 6'b111111;
            else if (lu)       exp_vec = 6'b001101;
            else               exp_vec = 6'b111100;
            check("model_bundle", 32'(bundle()), 32'(exp_vec));
            check("model_mem_error", 32'(mem_error), 32'(m_err));
            check("model_stall_count", 32'(stall_count), 32'(m_stall));
            check("model_flush_count", 32'(flush_count), 32'(m_flush));
            if (!exp_vec[5] && m_stall < CNT_MAX) m_stall++;
            if (!freeze && redirect && m_flush < CNT_MAX) m_flush++;
            if (!m_err && pending) begin
                if (mem_ready) begin
                    m_wait = 0; m_streak = 0;
                end else begin
                    m_wait = 1; m_streak++;
                    if (m_streak == MEM_TIMEOUT) m_err = 1;
                end
            end
        end
    end

    task automatic idle();
        enable_hazard_control = 1'b1;
        id_rs1 = '0; id_rs2 = '0; id_uses_rs2 = 1'b0;
        ex_memread = 1'b0; ex_rd = '0;
        ex_branch_taken = 1'b0; ex_jump = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    // Advance to just after the next rising edge; inputs change there.
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic load_use(input logic [4:0] rd, input logic [4:0] rs1);
        idle();
        ex_memread = 1'b1; ex_rd = rd; id_rs1 = rs1;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        #2;
        check("lit_reset_pc_write", 32'(pc_write), 32'h0);
        next(); next();
        rst_n = 1'b1;

        // Load-use on rs1: exactly one bubble.
        next(); load_use(5'd5, 5'd5);
        #1;
        check("lit_lu_bundle", 32'(bundle()), 32'h0D);
        next(); idle();
        #1;
        check("lit_lu_stall_count", 32'(stall_count), 32'd1);
        check("lit_lu_released", 32'(pc_write), 32'h1);

        // Non-stalling variants, then rs2 cases.
        next(); load_use(5'd0, 5'd0);
        #1; check("lit_rd0_no_stall", 32'(pc_write), 32'h1);
        next(); load_use(5'd5, 5'd5); enable_hazard_control = 1'b0;
        #1; check("lit_disabled_no_stall", 32'(pc_write), 32'h1);
        next(); load_use(5'd7, 5'd1); id_rs2 = 5'd7; id_uses_rs2 = 1'b1;
        #1; check("lit_rs2_stall", 32'(ifid_write), 32'h0);
        next(); load_use(5'd7, 5'd1); id_rs2 = 5'd7; id_uses_rs2 = 1'b0;
        #1; check("lit_rs2_unused", 32'(pc_write), 32'h1);

        // Redirect beats a simultaneous load-use.
        next(); load_use(5'd5, 5'd5); ex_jump = 1'b1;
        #1; check("lit_redirect_bundle", 32'(bundle()), 32'h3F);
        next(); idle(); ex_branch_taken = 1'b1;
        #1;
        check("lit_redirect_flush_count", 32'(flush_count), 32'd1);
        check("lit_redirect_stall_kept", 32'(stall_count), 32'd2);

        // Memory wait of 3 cycles with a taken branch held in EX.
        for (int i = 0; i < 3; i++) begin
            next(); idle(); mem_req = 1'b1; ex_branch_taken = 1'b1;
            #1; check("lit_wait_frozen", 32'(bundle()), 32'h0);
        end
        next(); idle(); mem_req = 1'b1; mem_ready = 1'b1; ex_branch_taken = 1'b1;
        #1; check("lit_wait_release_flush", 32'(bundle()), 32'h3F);
        next(); idle(); mem_req = 1'b1; mem_ready = 1'b1;
        #1;
        check("lit_wait_stall_count", 32'(stall_count), 32'd5);
        check("lit_wait_flush_count", 32'(flush_count), 32'd3);
        check("lit_ready_first_cycle", 32'(bundle()), 32'h3C);

        // Counter saturation after a reset.
        next(); idle(); rst_n = 1'b0;
        #1; check("lit_counters_cleared", 32'(stall_count), 32'd0);
        next(); rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            next(); load_use(5'd9, 5'd9);
            next(); idle();
        end
        #1; check("lit_stall_saturated", 32'(stall_count), 32'd7);

        // Timeout into ERR, sticky until reset.
        next(); idle(); rst_n = 1'b0;
        next(); rst_n = 1'b1;
        for (int i = 0; i < MEM_TIMEOUT; i++) begin
            next(); idle(); mem_req = 1'b1;
            #1;
            check("lit_timeout_frozen", 32'(pc_write), 32'h0);
            check("lit_timeout_no_err_yet", 32'(mem_error), 32'h0);
        end
        next(); idle(); mem_req = 1'b1;
        #1; check("lit_timeout_err", 32'(mem_error), 32'h1);
        next(); idle(); mem_req = 1'b1; mem_ready = 1'b1;
        next(); idle();
        #1;
        check("lit_err_sticky", 32'(mem_error), 32'h1);
        check("lit_err_frozen", 32'(bundle()), 32'h0);
        rst_n = 1'b0;
        #1; check("lit_err_async_clear", 32'(mem_error), 32'h0);
        next(); rst_n = 1'b1;
        #1; check("lit_after_err_normal", 32'(bundle()), 32'h3C);

        // Reset in the middle of a wait.
        next(); idle(); mem_req = 1'b1;
        next(); idle(); mem_req = 1'b1;
        next(); idle(); rst_n = 1'b0;
        next(); rst_n = 1'b1;
        #1; check("lit_wait_reset_run", 32'(pc_write), 32'h1);

        next(); next();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
